// File: rtl/icache_fill_ctrl.sv
// I-cache refill sequencer: one outstanding block load per demand miss, with an
// optional next-line prefetcher enabled by defining ICACHE_PREFETCH_EN.
module icache_fill_ctrl #(
  parameter int BLOCK_BYTES = 8,
  parameter int TAG_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             miss_valid,
  input  logic [31:0]      miss_addr,
  input  logic             restore_valid,
  output logic             miss_busy,
  input  logic             mem_gnt,
  output logic [1:0]       proc2mem_command,
  output logic [31:0]      proc2mem_addr,
  input  logic [TAG_W-1:0] mem2proc_transaction_tag,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_data_tag,
  output logic             fill_valid,
  output logic [31:0]      fill_addr,
  output logic [63:0]      fill_data,
  output logic             fill_is_demand,
  output logic [31:0]      pf_probe_addr,
  input  logic             pf_present
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
  localparam logic [1:0]  BUS_NONE = 2'd0;
  localparam logic [1:0]  BUS_LOAD = 2'd1;
  localparam logic [31:0] BLK_MASK = ~(32'(BLOCK_BYTES) - 32'd1);

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [63:0]        data_q, data_d;
  logic               is_pf_q, is_pf_d, squashed_q, squashed_d;
  logic [31:0]        pf_addr_q, pf_addr_d;
  logic               pf_vld_q, pf_vld_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      is_pf_q    <= 1'b0;
      squashed_q <= 1'b0;
      pf_addr_q  <= '0;
      pf_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      is_pf_q    <= is_pf_d;
      squashed_q <= squashed_d;
      pf_addr_q  <= pf_addr_d;
      pf_vld_q   <= pf_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    data_d     = data_q;
    is_pf_d    = is_pf_q;
    squashed_d = squashed_q;
    pf_addr_d  = pf_addr_q;
    pf_vld_d   = pf_vld_q;
    case (state_q)
      IDLE: begin
        if (miss_valid) begin
          // a demand miss always wins; any pending prefetch candidate is dropped
          pf_vld_d = 1'b0;
          if (!restore_valid) begin
            addr_d     = miss_addr & BLK_MASK;
            tag_d      = '0;
            is_pf_d    = 1'b0;
            squashed_d = 1'b0;
            state_d    = REQ;
          end
        end
`ifdef ICACHE_PREFETCH_EN
        else if (pf_vld_q) begin
          pf_vld_d = 1'b0;
          if (!pf_present) begin
            addr_d     = pf_addr_q;
            tag_d      = '0;
            is_pf_d    = 1'b1;
            squashed_d = 1'b0;
            state_d    = REQ;
          end
        end
`endif
      end
      REQ: begin
        // once memory has taken the request it cannot be cancelled, so a
        // same-cycle redirect only marks the fill as squashed
        if (mem_gnt && (mem2proc_transaction_tag != '0)) begin
          tag_d      = mem2proc_transaction_tag;
          squashed_d = restore_valid && !is_pf_q;
          state_d    = WAIT;
        end else if (restore_valid && !is_pf_q) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (restore_valid && !is_pf_q) squashed_d = 1'b1;
        if ((tag_q != '0) && (mem2proc_data_tag == tag_q)) begin
          data_d  = mem2proc_data;
          tag_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        state_d = IDLE;
`ifdef ICACHE_PREFETCH_EN
        if (!is_pf_q) begin
          pf_addr_d = addr_q + 32'(BLOCK_BYTES);
          pf_vld_d  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign miss_busy        = (state_q != IDLE);
  assign proc2mem_command = (state_q == REQ) ? BUS_LOAD : BUS_NONE;
  assign proc2mem_addr    = (state_q == REQ) ? addr_q : '0;
  assign fill_valid       = (state_q == FILL);
  assign fill_addr        = (state_q == FILL) ? addr_q : '0;
  assign fill_data        = (state_q == FILL) ? data_q : '0;
  assign fill_is_demand   = (state_q == FILL) && !is_pf_q && !squashed_q;

`ifdef ICACHE_PREFETCH_EN
  assign pf_probe_addr = pf_vld_q ? pf_addr_q : '0;
`else
  logic unused_pf_present;
  assign unused_pf_present = pf_present;
  assign pf_probe_addr     = '0;
`endif
endmodule
